// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding UartTX: buffers host writes and launches one frame at a time,
// pacing on trc_i and flagging frames whose start never appears.
module uart_tx_fifo #(
  parameter int DEPTH         = 16,
  parameter int BIT_N         = 8,
  parameter int START_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [BIT_N-1:0]         wr_data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovf_o,
  input  logic                     ovf_clr_i,
  output logic                     tmo_o,
  output logic [BIT_N-1:0]         data_o,
  output logic                     data_rdy_o,
  input  logic                     trc_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(START_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;

  state_t           state, state_nx;
  logic [BIT_N-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [TW-1:0]    timer;
  logic             pop, wr_acc, ovf_set, tmo_set, timer_clr, timer_inc;

  assign count_o    = wr_ptr - rd_ptr;
  assign empty_o    = (count_o == '0);
  assign full_o     = (count_o == (AW+1)'(DEPTH));
  assign data_rdy_o = (state == LAUNCH);

  // A pop frees a slot in the same cycle, so a write alongside it is never dropped.
  assign pop     = (state == IDLE) && !empty_o;
  assign wr_acc  = wr_en_i && (!full_o || pop);
  assign ovf_set = wr_en_i && full_o && !pop;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      data_o <= '0;
      ovf_o  <= 1'b0;
      tmo_o  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_o <= mem[rd_ptr[AW-1:0]];
      end
      if (ovf_set)        ovf_o <= 1'b1;
      else if (ovf_clr_i) ovf_o <= 1'b0;
      if (tmo_set) tmo_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nx;
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    tmo_set   = 1'b0;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    case (state)
      IDLE:       if (pop) state_nx = LAUNCH;
      LAUNCH: begin
        timer_clr = 1'b1;
        state_nx  = WAIT_START;
      end
      WAIT_START: begin
        if (trc_i) begin
          state_nx = WAIT_DONE;
        end else if (timer == TW'(START_TIMEOUT - 1)) begin
          // The byte is abandoned; the transmitter never acknowledged it.
          tmo_set  = 1'b1;
          state_nx = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      WAIT_DONE:  if (!trc_i) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench for uart_tx_fifo with a behavioural UartTX responder.
module tb_uart_tx_fifo;
  localparam int DEPTH = 8;
  localparam int BIT_N = 8;
  localparam int ST    = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [BIT_N-1:0] wr_data = '0;
  logic             full, empty, ovf, tmo, data_rdy;
  logic             ovf_clr = 1'b0;
  logic             trc = 1'b0;
  logic [3:0]       count;
  logic [BIT_N-1:0] data;

  int checks = 0;
  int fails  = 0;
  int pulses = 0;
  int peak   = 0;
  int tx_mode = 0;  // 0: responder drives trc, 1: test drives trc
  bit prev_rdy = 1'b0;
  logic [BIT_N-1:0] exp_q[$];

  uart_tx_fifo #(.DEPTH(DEPTH), .BIT_N(BIT_N), .START_TIMEOUT(ST)) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .full_o(full), .empty_o(empty), .count_o(count), .ovf_o(ovf),
    .ovf_clr_i(ovf_clr), .tmo_o(tmo), .data_o(data), .data_rdy_o(data_rdy),
    .trc_i(trc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every launch must carry the oldest outstanding byte.
  always @(negedge clk) begin
    if (rst) begin
      prev_rdy = 1'b0;
    end else begin
      chk("empty_vs_count", int'(empty), int'(count == 0));
      chk("full_vs_count", int'(full), int'(count == DEPTH));
      if (int'(count) > peak) peak = int'(count);
      if (data_rdy) begin
        pulses++;
        chk("rdy_single_cycle", int'(prev_rdy), 0);
        if (tx_mode == 0) chk("rdy_after_trc_fall", int'(trc), 0);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_rdy actual_data=%0h required=no_pulse", data);
        end else begin
          chk("data_o", int'(data), int'(exp_q.pop_front()));
        end
      end
      prev_rdy = data_rdy;
    end
  end

  // Behavioural UartTX: frame starts 1-3 cycles after data_rdy, lasts 2-8 cycles.
  initial forever begin
    @(negedge clk);
    if (tx_mode == 0 && data_rdy && !rst) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 trc = 1'b1;
      repeat ($urandom_range(2, 8)) @(posedge clk);
      #1 trc = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [BIT_N-1:0] b, input bit acc);
    wr_en = 1'b1;
    wr_data = b;
    if (acc) exp_q.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && count == 0 && !data_rdy) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_time", int'(n < budget), 1);
    repeat (14) step();
    chk("drain_trc_low", int'(trc), 0);
  endtask

  initial begin
    int p0, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_tmo", int'(tmo), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_rdy", int'(data_rdy), 0);
    rst = 1'b0;
    step();

    // Single byte: pop one cycle after the write, pulse one after that.
    wr(8'h47, 1'b1);
    chk("t1_rdy_n1", int'(data_rdy), 0);
    chk("t1_count_n1", int'(count), 1);
    step();
    chk("t1_rdy_n2", int'(data_rdy), 1);
    chk("t1_data_n2", int'(data), 8'h47);
    wait_drain(200);

    // Back-to-back burst.
    peak = 0;
    p0 = pulses;
    wr(8'h47, 1'b1);
    wr(8'h9B, 1'b1);
    wr(8'h00, 1'b1);
    wr(8'hFF, 1'b1);
    wait_drain(400);
    chk("t2_peak", peak, 3);
    chk("t2_pulses", pulses - p0, 4);

    // Random traffic, never exceeding capacity.
    for (int i = 0; i < 400; i++) begin
      chk("rand_count_bound",
          int'(int'(count) <= exp_q.size() && int'(count) + 1 >= exp_q.size()), 1);
      if (exp_q.size() < DEPTH && $urandom_range(0, 9) < 4) wr(8'($urandom), 1'b1);
      else step();
    end
    wait_drain(2000);

    // Overflow: park one frame in flight, then overfill.
    tx_mode = 1;
    wr(8'h11, 1'b1);
    step();
    trc = 1'b1;
    step();
    step();
    for (int i = 0; i < DEPTH + 2; i++) wr(8'($urandom), i < DEPTH);
    chk("t3_full", int'(full), 1);
    chk("t3_ovf", int'(ovf), 1);
    chk("t3_count", int'(count), DEPTH);
    ovf_clr = 1'b1;
    wr(8'hEE, 1'b0);
    chk("t3_set_beats_clr", int'(ovf), 1);
    step();
    ovf_clr = 1'b0;
    chk("t3_ovf_cleared", int'(ovf), 0);
    chk("t3_still_full", int'(full), 1);

    // Write while full with a pop due the same cycle.
    trc = 1'b0;
    step();
    tx_mode = 0;
    wr(8'hA5, 1'b1);
    chk("t4_count", int'(count), DEPTH);
    chk("t4_ovf", int'(ovf), 0);
    wait_drain(1000);

    // Start timeout.
    tx_mode = 1;
    trc = 1'b0;
    wr(8'h3C, 1'b1);
    step();
    chk("t5_launch", int'(data_rdy), 1);
    step();
    chk("t5_tmo_entry", int'(tmo), 0);
    repeat (ST - 1) step();
    chk("t5_tmo_early", int'(tmo), 0);
    step();
    chk("t5_tmo_set", int'(tmo), 1);
    chk("t5_count", int'(count), 0);
    repeat (5) step();
    chk("t5_tmo_sticky", int'(tmo), 1);
    tx_mode = 0;

    // Reset mid-frame.
    wr(8'h01, 1'b1);
    wr(8'h02, 1'b1);
    wr(8'h03, 1'b1);
    n = 0;
    while (!trc && n < 50) begin
      step();
      n++;
    end
    chk("t6_frame_started", int'(trc), 1);
    rst = 1'b1;
    exp_q.delete();
    step();
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_empty", int'(empty), 1);
    chk("t6_rst_full", int'(full), 0);
    chk("t6_rst_ovf", int'(ovf), 0);
    chk("t6_rst_tmo", int'(tmo), 0);
    chk("t6_rst_data", int'(data), 0);
    chk("t6_rst_rdy", int'(data_rdy), 0);
    repeat (4) step();
    rst = 1'b0;
    p0 = pulses;
    repeat (15) step();
    chk("t6_no_launch", pulses - p0, 0);
    wr(8'h9B, 1'b1);
    wait_drain(200);
    chk("t6_one_launch", pulses - p0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
